// File: rtl/hsv_core_commit_arbiter_if.sv
// Commit payload types and the unit/commit handshake bundle for the commit-order arbiter.
package hsv_core_commit_arbiter_pkg;
  localparam int unsigned NumUnits = 5;
  localparam int unsigned TokenW   = 8;
  localparam int unsigned XlenW    = 32;

  typedef logic [TokenW-1:0] insn_token_t;

  typedef struct packed {
    insn_token_t      token;
    logic [XlenW-1:0] pc;
  } commit_common_t;

  typedef struct packed {
    commit_common_t   common;
    logic             trap;
    logic             jump;
    logic [XlenW-1:0] result;
  } commit_data_t;
endpackage

interface hsv_core_commit_arbiter_if;
  import hsv_core_commit_arbiter_pkg::*;

  logic                        flush;
  logic         [NumUnits-1:0] in_valid;
  commit_data_t [NumUnits-1:0] in_data;
  logic         [NumUnits-1:0] in_ready;
  logic                        out_valid;
  commit_data_t                out_data;
  logic                        out_ready;
  insn_token_t                 expected_token;
  logic                        order_error;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, expected_token, order_error
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, expected_token, order_error
  );
endinterface

// File: rtl/hsv_core_commit_arbiter.sv
// Accepts only the execution-unit result carrying the next expected token and
// forwards it to commit through a one-entry output register.
module hsv_core_commit_arbiter
  import hsv_core_commit_arbiter_pkg::*;
(
  input  logic                     clk_core,
  input  logic                     rst_core_n,
  hsv_core_commit_arbiter_if.slave bus
);
  localparam int unsigned SelW = $clog2(NumUnits);
  localparam int unsigned CntW = $clog2(NumUnits + 1);

  logic [NumUnits-1:0] match;
  logic [SelW-1:0]     sel;
  logic [CntW-1:0]     match_cnt;
  logic                any_match;
  logic                multi_match;
  logic                space;
  logic                accept;

  // Token match per unit; descending scan leaves the lowest matching index in sel.
  always_comb begin
    match     = '0;
    sel       = '0;
    match_cnt = '0;
    for (int unsigned i = 0; i < NumUnits; i++) begin
      match[i]  = bus.in_valid[i] && (bus.in_data[i].common.token == bus.expected_token);
      match_cnt = match_cnt + CntW'(match[i]);
    end
    for (int i = int'(NumUnits) - 1; i >= 0; i--) begin
      if (match[i]) sel = SelW'(i);
    end
  end

  assign any_match   = |match;
  assign multi_match = match_cnt > CntW'(1);
  assign space       = !bus.out_valid || bus.out_ready;
  assign accept      = rst_core_n && !bus.flush && space && any_match;

  always_comb begin
    bus.in_ready = '0;
    if (accept) bus.in_ready[sel] = 1'b1;
  end

  // Output register; flush discards the held entry and restarts the token sequence.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.expected_token <= '0;
      bus.order_error    <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid      <= 1'b0;
      bus.expected_token <= '0;
      bus.order_error    <= 1'b0;
    end else begin
      bus.order_error <= multi_match;
      if (accept) begin
        bus.out_data       <= bus.in_data[sel];
        bus.out_valid      <= 1'b1;
        bus.expected_token <= bus.expected_token + TokenW'(1);
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hsv_core_commit_arbiter.sv
// Directed vector bench for hsv_core_commit_arbiter: a table of single-cycle
// vectors plus hand-written reset, wrap-around and reset-mid-operation sequences.
module tb_hsv_core_commit_arbiter;
  import hsv_core_commit_arbiter_pkg::*;

  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  hsv_core_commit_arbiter_if bus ();

  hsv_core_commit_arbiter dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .bus        (bus)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [4:0]  v;
    logic [39:0] toks;
    logic        ordy;
    logic        fl;
    logic [4:0]  rdy;
    logic        ov;
    int          unit;
    logic [7:0]  otok;
    logic [7:0]  exp_tok;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic commit_data_t mk(input int unit, input logic [7:0] t);
    commit_data_t d;
    d.common.token = t;
    d.common.pc    = (32'(unit) << 16) | 32'(t);
    d.trap         = t[0];
    d.jump         = unit[0];
    d.result       = ~d.common.pc ^ 32'h5a5a_0000;
    return d;
  endfunction

  function automatic void add(input logic [4:0] v, input logic [39:0] toks, input logic ordy,
                              input logic fl, input logic [4:0] rdy, input logic ov, input int unit,
                              input logic [7:0] otok, input logic [7:0] exp_tok, input logic err);
    vec_t x;
    x.v = v; x.toks = toks; x.ordy = ordy; x.fl = fl; x.rdy = rdy;
    x.ov = ov; x.unit = unit; x.otok = otok; x.exp_tok = exp_tok; x.err = err;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h want %0h", name, act, req);
    else n_pass++;
  endtask

  task automatic drive(input logic [4:0] v, input logic [39:0] toks, input logic ordy, input logic fl);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid[i] = v[i];
      bus.in_data[i]  = mk(i, toks[8*i +: 8]);
    end
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic apply(input vec_t x, input int idx);
    @(negedge clk_core);
    drive(x.v, x.toks, x.ordy, x.fl);
    #1;
    chk($sformatf("v%0d in_ready", idx), 128'(bus.in_ready), 128'(x.rdy));
    @(posedge clk_core);
    #1;
    chk($sformatf("v%0d out_valid", idx), 128'(bus.out_valid), 128'(x.ov));
    chk($sformatf("v%0d expected_token", idx), 128'(bus.expected_token), 128'(x.exp_tok));
    chk($sformatf("v%0d order_error", idx), 128'(bus.order_error), 128'(x.err));
    if (x.ov) chk($sformatf("v%0d out_data", idx), 128'(bus.out_data), 128'(mk(x.unit, x.otok)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] t;

    // In-order across units: alu 0, mem 1, branch 2.
    t = {8'd0, 8'd2, 8'd1, 8'd0, 8'd0};
    add(5'b01101, t, 1, 0, 5'b00001, 1, 0, 8'd0, 8'd1, 0);
    add(5'b01100, t, 1, 0, 5'b00100, 1, 2, 8'd1, 8'd2, 0);
    add(5'b01000, t, 1, 0, 5'b01000, 1, 3, 8'd2, 8'd3, 0);
    add(5'b00000, t, 1, 0, 5'b00000, 0, 0, 8'd0, 8'd3, 0);
    add(5'b00000, t, 0, 1, 5'b00000, 0, 0, 8'd0, 8'd0, 0);
    // Out-of-order: ctrlstatus token 1 waits for foo token 0.
    t = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int k = 0; k < 3; k++) add(5'b10000, t, 1, 0, 5'b00000, 0, 0, 8'd0, 8'd0, 0);
    add(5'b10010, t, 1, 0, 5'b00010, 1, 1, 8'd0, 8'd1, 0);
    add(5'b10000, t, 1, 0, 5'b10000, 1, 4, 8'd1, 8'd2, 0);
    add(5'b00000, t, 1, 0, 5'b00000, 0, 0, 8'd0, 8'd2, 0);
    // Backpressure: alu token 2 held for 5 cycles, foo token 3 waits.
    t = {8'd0, 8'd0, 8'd0, 8'd3, 8'd2};
    add(5'b00001, t, 0, 0, 5'b00001, 1, 0, 8'd2, 8'd3, 0);
    for (int k = 0; k < 5; k++) add(5'b00010, t, 0, 0, 5'b00000, 1, 0, 8'd2, 8'd3, 0);
    add(5'b00010, t, 1, 0, 5'b00010, 1, 1, 8'd3, 8'd4, 0);
    add(5'b00000, t, 1, 0, 5'b00000, 0, 0, 8'd0, 8'd4, 0);
    // Flush with a held entry while mem presents the matching token.
    t = {8'd0, 8'd0, 8'd5, 8'd0, 8'd4};
    add(5'b00001, t, 0, 0, 5'b00001, 1, 0, 8'd4, 8'd5, 0);
    add(5'b00100, t, 0, 1, 5'b00000, 0, 0, 8'd0, 8'd0, 0);
    add(5'b00001, 40'd0, 1, 0, 5'b00001, 1, 0, 8'd0, 8'd1, 0);
    // Duplicate token: alu wins over branch, error pulses once.
    t = {8'd0, 8'd1, 8'd0, 8'd0, 8'd1};
    add(5'b01001, t, 1, 0, 5'b00001, 1, 0, 8'd1, 8'd2, 1);
    add(5'b01000, t, 1, 0, 5'b00000, 0, 0, 8'd0, 8'd2, 0);
    // Duplicate during flush: flush wins, no error.
    t = {8'd0, 8'd0, 8'd0, 8'd2, 8'd2};
    add(5'b00011, t, 1, 1, 5'b00000, 0, 0, 8'd0, 8'd0, 0);
    // Duplicate between foo and mem: lowest index (foo) wins.
    add(5'b00110, 40'd0, 1, 0, 5'b00010, 1, 1, 8'd0, 8'd1, 1);
    add(5'b00000, 40'd0, 1, 0, 5'b00000, 0, 0, 8'd0, 8'd1, 0);

    // Reset state, with alu presenting token 0 while reset is held.
    drive(5'b00001, 40'd0, 1, 0);
    #12;
    chk("reset in_ready", 128'(bus.in_ready), 128'd0);
    chk("reset out_valid", 128'(bus.out_valid), 128'd0);
    chk("reset out_data", 128'(bus.out_data), 128'd0);
    chk("reset expected_token", 128'(bus.expected_token), 128'd0);
    chk("reset order_error", 128'(bus.order_error), 128'd0);
    drive(5'b00000, 40'd0, 1, 0);
    @(negedge clk_core);
    rst_core_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Wrap-around: 258 back-to-back alu results starting from token 0.
    @(negedge clk_core);
    drive(5'b00000, 40'd0, 1, 1);
    for (int k = 0; k < 258; k++) begin
      @(negedge clk_core);
      drive(5'b00001, {32'd0, 8'(k)}, 1, 0);
      #1;
      chk($sformatf("wrap%0d in_ready", k), 128'(bus.in_ready), 128'd1);
      @(posedge clk_core);
      #1;
      chk($sformatf("wrap%0d out", k), {bus.out_valid, bus.out_data, bus.expected_token},
          {1'b1, mk(0, 8'(k)), 8'(k + 1)});
    end

    // Reset mid-operation drops the held entry; first accept is token 0.
    @(negedge clk_core);
    drive(5'b00001, {32'd0, 8'd2}, 0, 0);
    @(negedge clk_core);
    rst_core_n = 1'b0;
    drive(5'b00001, 40'd0, 1, 0);
    #1;
    chk("midrst out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst expected_token", 128'(bus.expected_token), 128'd0);
    chk("midrst in_ready", 128'(bus.in_ready), 128'd0);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    #1;
    chk("postrst in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk_core);
    #1;
    chk("postrst out", {bus.out_valid, bus.out_data, bus.expected_token},
        {1'b1, mk(0, 8'd0), 8'd1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
